// File: rtl/fb_display_reader.sv
// Frame buffer display reader: maps display timing to frame buffer reads, fixed 3-clk latency.
// Optional pixel doubling (640x480 window for a 320x240 buffer) with macro FB_SCALE2X_EN.
module fb_display_reader #(
    parameter int c_img_cols     = 320,
    parameter int c_img_rows     = 240,
    parameter int c_nb_img_pxls  = 17,
    parameter int c_nb_buf_red   = 4,
    parameter int c_nb_buf_green = 4,
    parameter int c_nb_buf_blue  = 4,
    parameter int c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      visible,
    input  logic [9:0]                col,
    input  logic [9:0]                row,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    output logic [c_nb_img_pxls-1:0]  rd_addr,
    input  logic [c_nb_buf-1:0]       rd_data,
    output logic [c_nb_buf_red-1:0]   red,
    output logic [c_nb_buf_green-1:0] green,
    output logic [c_nb_buf_blue-1:0]  blue,
    output logic                      hsync_out,
    output logic                      vsync_out
);

    localparam int c_img_pxls = c_img_cols * c_img_rows;
`ifdef FB_SCALE2X_EN
    localparam int c_win_cols = 2 * c_img_cols;
    localparam int c_win_rows = 2 * c_img_rows;
`else
    localparam int c_win_cols = c_img_cols;
    localparam int c_win_rows = c_img_rows;
`endif
    localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_pxls - 1);
    localparam logic [c_nb_img_pxls-1:0] c_one       = c_nb_img_pxls'(1);

    logic                     in_win;
    logic                     pix_en;
    logic                     frame_start;
    logic [c_nb_img_pxls-1:0] addr_q;
    logic [c_nb_img_pxls-1:0] cur_addr;
    logic [c_nb_img_pxls-1:0] cur_inc;
    logic                     locked_q;
    logic [2:0]               hs_pipe;
    logic [2:0]               vs_pipe;
    logic [1:0]               win_pipe;
    logic [1:0]               lock_pipe;
    logic                     show;

    assign in_win      = ({1'b0, col} < 11'(c_win_cols)) && ({1'b0, row} < 11'(c_win_rows));
    assign pix_en      = visible && in_win;
    assign frame_start = visible && (col == '0) && (row == '0);
    // Frame start restarts the scan at address 0 in the same cycle it is seen.
    assign cur_addr    = frame_start ? '0 : addr_q;
    assign cur_inc     = (cur_addr == c_last_addr) ? '0 : cur_addr + c_one;

`ifdef FB_SCALE2X_EN
    logic [c_nb_img_pxls-1:0] line_q;
    logic                     last_col;

    assign last_col = ({1'b0, col} == 11'(c_win_cols - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            line_q  <= '0;
            rd_addr <= '0;
        end else if (pix_en) begin
            rd_addr <= cur_addr;
            if (frame_start) begin
                line_q <= '0;
            end
            if (last_col) begin
                // Even line replays from line start; odd line commits the next line start.
                if (row[0]) begin
                    addr_q <= cur_inc;
                    line_q <= cur_inc;
                end else begin
                    addr_q <= line_q;
                end
            end else if (col[0]) begin
                addr_q <= cur_inc;
            end else begin
                addr_q <= cur_addr;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rd_addr <= '0;
        end else if (pix_en) begin
            rd_addr <= cur_addr;
            addr_q  <= cur_inc;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= 1'b0;
        end else if (frame_start) begin
            locked_q <= 1'b1;
        end
    end

    // Flags ride along with the read: stage 0 at rd_addr, stage 1 at RAM data, colour reg last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_pipe   <= '1;
            vs_pipe   <= '1;
            win_pipe  <= '0;
            lock_pipe <= '0;
        end else begin
            hs_pipe   <= {hs_pipe[1:0], hsync_in};
            vs_pipe   <= {vs_pipe[1:0], vsync_in};
            win_pipe  <= {win_pipe[0], pix_en};
            lock_pipe <= {lock_pipe[0], locked_q | frame_start};
        end
    end

    assign show      = win_pipe[1] && lock_pipe[1];
    assign hsync_out = hs_pipe[2];
    assign vsync_out = vs_pipe[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (show) begin
            red   <= rd_data[c_nb_buf-1 -: c_nb_buf_red];
            green <= rd_data[c_nb_buf_green+c_nb_buf_blue-1 -: c_nb_buf_green];
            blue  <= rd_data[c_nb_buf_blue-1:0];
        end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end
    end

endmodule

// File: doc/fb_display_reader.md
FB_DISPLAY_READER -- requirements
Module: fb_display_reader

Interface
REQ-001 SHALL have parameter c_img_cols, default 320, image width in pixels.
REQ-002 SHALL have parameter c_img_rows, default 240, image height in lines.
REQ-003 SHALL have parameter c_nb_img_pxls, default 17, frame buffer address width.
REQ-004 SHALL have parameters c_nb_buf_red, c_nb_buf_green, c_nb_buf_blue, default 4 each, colour field widths; c_nb_buf = sum (default 12).
REQ-005 SHALL have port clk, input, 1, single clock: pixel clock and frame buffer read clock.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port visible, input, 1, display timing: active video this cycle.
REQ-008 SHALL have port col, input, 10, display column of the current cycle.
REQ-009 SHALL have port row, input, 10, display line of the current cycle.
REQ-010 SHALL have ports hsync_in and vsync_in, input, 1 each, active-low syncs from the timing generator.
REQ-011 SHALL have port rd_addr, output, c_nb_img_pxls, registered frame buffer read address.
REQ-012 SHALL have port rd_data, input, c_nb_buf, frame buffer read data: {red, green, blue}, red in the MSBs, valid one clk after rd_addr is sampled.
REQ-013 SHALL have ports red, green, blue, output, c_nb_buf_red/green/blue, registered pixel colour.
REQ-014 SHALL have ports hsync_out and vsync_out, output, 1 each, syncs aligned with the colour outputs.

Function
REQ-015 SHALL define the image window as col < W and row < H, where W = c_img_cols and H = c_img_rows (2*W and 2*H with FB_SCALE2X_EN).
REQ-016 SHALL generate rd_addr from counters (address counter and line-start register), no multiplier; rd_addr = row*c_img_cols + col (1x), or (row>>1)*c_img_cols + (col>>1) (2x).
REQ-017 SHALL register that value into rd_addr on the edge after a cycle with visible=1 inside the window; outside the window, rd_addr SHALL hold.
REQ-018 SHALL treat visible=1, col=0, row=0 as frame start: reload address counter and line-start to 0 and set the internal frame_locked flag.
REQ-019 SHALL never drive rd_addr above c_img_pxls-1; after the last window pixel the counter SHALL wrap to 0.
REQ-020 SHALL align outputs to a fixed latency of 3 clk after col/row/visible/syncs are presented: rd_addr at +1, RAM data at +2, output registers at +3.
REQ-021 SHALL delay hsync_in, vsync_in, the in-window flag and frame_locked each through a 3-stage pipeline.
REQ-022 SHALL output rd_data fields on red/green/blue when the delayed in-window flag and delayed frame_locked are both 1; otherwise SHALL output 0 (black).
REQ-023 SHALL keep frame_locked at 0 from reset until the first frame start, so pixels before it are black.

Reset
REQ-024 SHALL, on rst_n=0 (asynchronous), clear rd_addr, counters, line-start, frame_locked and all pipeline stages, and drive red/green/blue = 0 and hsync_out/vsync_out = 1.
REQ-025 SHALL, on reset released mid-frame, output black until the next frame start, then output normal video.

Configuration
REQ-026 SHALL use macro FB_SCALE2X_EN: when defined, each image pixel repeats on 2 columns and each image line on 2 display lines (640x480 window for defaults).
REQ-027 SHALL, with FB_SCALE2X_EN defined, advance the address on odd col; at the last window column of an even row, reload the address from line-start; at the last window column of an odd row, load line-start with the advanced address.
REQ-028 SHALL, without FB_SCALE2X_EN, advance the address every window pixel (320x240 window at top-left, black elsewhere).

Verification
REQ-029 SHALL cover reset: rst_n=0 mid-line -> red/green/blue=0, syncs=1 immediately, with no clk edge.
REQ-030 SHALL cover 1x mapping: frame start then col=5,row=2 visible -> rd_addr=645 one clk later; rd_data=12'hABC returned -> red=A, green=B, blue=C at +3.
REQ-031 SHALL cover the window edge in 1x: col=320,row=0 -> rd_addr holds 319, output black at +3; row=239,col=319 -> rd_addr=76799, then wraps to 0 at next frame start.
REQ-032 SHALL cover 2x mapping: col=0..3 on row 0 -> rd_addr 0,0,1,1; rows 0 and 1 same sequence; row 2,col=0 -> rd_addr=320.
REQ-033 SHALL cover lock: reset released at row=100 -> black output until row=0,col=0, first pixel at +3 = rd_data.
REQ-034 SHALL cover sync alignment: hsync_in pulse low for 96 clk -> hsync_out low for 96 clk starting exactly 3 clk later.
